id_gen: RTL

Identifier stream generator. It emits one ASCII character per handshake that together form a legal identifier: one or more letters followed by an optional decimal number. It is the transmit-side counterpart of the identifier-recognising FSM. It feeds the same 8-bit character bus that recogniser consumes, and serves both as a stimulus source and as the name emitter in the token path.

---
 rtl/id_gen_pkg.sv | 31 +++
 rtl/id_gen_if.sv | 25 ++
 rtl/id_gen_bin2bcd.sv | 52 +++++
 rtl/id_gen.sv | 95 +++++++++
 4 files changed

// File: rtl/id_gen_pkg.sv
// id_gen_pkg: shared ASCII constants, FSM states and character helpers for the identifier path
package id_gen_pkg;

   localparam logic [7:0] CH_A_UP = 8'h41;
   localparam logic [7:0] CH_Z_UP = 8'h5A;
   localparam logic [7:0] CH_A_LO = 8'h61;
   localparam logic [7:0] CH_Z_LO = 8'h7A;
   localparam logic [7:0] CH_0    = 8'h30;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      LET  = 2'd2,
      DIG  = 2'd3
   } state_e;

   function automatic logic is_letter(input logic [7:0] c);
      return (c >= CH_A_UP && c <= CH_Z_UP) || (c >= CH_A_LO && c <= CH_Z_LO);
   endfunction

   // Anything that is not a letter starts the identifier at 'a'.
   function automatic logic [7:0] sanitize(input logic [7:0] c);
      return is_letter(c) ? c : CH_A_LO;
   endfunction

   // Successor letter, wrapping inside the same case.
   function automatic logic [7:0] next_letter(input logic [7:0] c);
      return c == CH_Z_LO ? CH_A_LO : c == CH_Z_UP ? CH_A_UP : c + 8'd1;
   endfunction

endpackage

// File: rtl/id_gen_if.sv
// id_gen_if: request and character-stream signals of the identifier generator
interface id_gen_if #(
   parameter int NUM_W = 16
);
   logic             start_i;
   logic [7:0]       prefix_i;
   logic [3:0]       nlet_i;
   logic             has_num_i;
   logic [NUM_W-1:0] num_i;
   logic             ready_i;
   logic [7:0]       char_o;
   logic             valid_o;
   logic             last_o;
   logic             busy_o;

   modport master (
      input  start_i, prefix_i, nlet_i, has_num_i, num_i, ready_i,
      output char_o, valid_o, last_o, busy_o
   );

   modport slave (
      output start_i, prefix_i, nlet_i, has_num_i, num_i, ready_i,
      input  char_o, valid_o, last_o, busy_o
   );
endinterface

// File: rtl/id_gen_bin2bcd.sv
// id_gen_bin2bcd: sequential double-dabble, one bit per cycle, done pulses after NUM_W shifts
module id_gen_bin2bcd #(
   parameter int NUM_W = 16,
   parameter int DIG_N = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               go,
   input  logic [NUM_W-1:0]   bin,
   output logic [4*DIG_N-1:0] bcd,
   output logic               done
);
   localparam int CNT_W = $clog2(NUM_W + 1);

   logic [NUM_W-1:0]   bin_q;
   logic [4*DIG_N-1:0] bcd_q, bcd_d, adj;
   logic [CNT_W-1:0]   cnt_q;
   logic               done_q;

   // add-3 correction on every digit >= 5, then shift in the next binary bit
   always_comb begin
      adj = bcd_q;
      for (int k = 0; k < DIG_N; k++)
         adj[4*k +: 4] = bcd_q[4*k +: 4] >= 4'd5 ? bcd_q[4*k +: 4] + 4'd3 : bcd_q[4*k +: 4];
      bcd_d = (adj << 1) | {{(4*DIG_N-1){1'b0}}, bin_q[NUM_W-1]};
   end

   // conversion register: load on go, then shift for NUM_W cycles
   always_ff @(posedge clk) begin
      if (reset) begin
         bin_q  <= '0;
         bcd_q  <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else if (go) begin
         bin_q  <= bin;
         bcd_q  <= '0;
         cnt_q  <= CNT_W'(NUM_W);
         done_q <= 1'b0;
      end else if (cnt_q != '0) begin
         bin_q  <= bin_q << 1;
         bcd_q  <= bcd_d;
         cnt_q  <= cnt_q - CNT_W'(1);
         done_q <= cnt_q == CNT_W'(1);
      end else begin
         done_q <= 1'b0;
      end
   end

   assign bcd  = bcd_q;
   assign done = done_q;
endmodule

// File: rtl/id_gen.sv
// id_gen: emits a legal identifier (letters then optional decimal suffix) one character per handshake
module id_gen
   import id_gen_pkg::*;
#(
   parameter int NUM_W = 16,
   parameter int DIG_N = 5
) (
   input logic       clk,
   input logic       reset,
   id_gen_if.master  bus
);
   localparam int IDX_W = $clog2(DIG_N + 1);

   state_e             state_q, state_d;
   logic [7:0]         let_q, let_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               has_num_q, has_num_d;
   logic [IDX_W-1:0]   idx_q, idx_d, msd;
   logic [4*DIG_N-1:0] bcd;
   logic [3:0]         dig;
   logic               conv_go, conv_done, hs;

   assign conv_go = state_q == IDLE && bus.start_i;

   id_gen_bin2bcd #(.NUM_W(NUM_W), .DIG_N(DIG_N)) u_bin2bcd (
      .clk  (clk),
      .reset(reset),
      .go   (conv_go),
      .bin  (bus.num_i),
      .bcd  (bcd),
      .done (conv_done)
   );

   // leading-zero scan: index of the most significant non-zero digit, 0 for a zero value
   always_comb begin
      msd = '0;
      for (int k = 0; k < DIG_N; k++)
         if (bcd[4*k +: 4] != 4'd0) msd = IDX_W'(k);
   end

   assign dig         = bcd[{idx_q, 2'b00} +: 4];
   assign bus.valid_o = state_q == LET || state_q == DIG;
   assign bus.busy_o  = state_q != IDLE;
   assign bus.char_o  = state_q == LET ? let_q : state_q == DIG ? CH_0 + {4'd0, dig} : 8'h00;
   assign bus.last_o  = state_q == LET ? cnt_q == 4'd1 && !has_num_q : state_q == DIG && idx_q == '0;
   assign hs          = bus.valid_o && bus.ready_i;

   // next state, letter/digit sequencing and request capture
   always_comb begin
      state_d   = state_q;
      let_d     = let_q;
      cnt_d     = cnt_q;
      has_num_d = has_num_q;
      idx_d     = idx_q;
      unique case (state_q)
         IDLE: if (bus.start_i) begin
            state_d   = CONV;
            let_d     = sanitize(bus.prefix_i);
            cnt_d     = bus.nlet_i == 4'd0 ? 4'd1 : bus.nlet_i;
            has_num_d = bus.has_num_i;
         end
         CONV: if (conv_done) begin
            state_d = LET;
            idx_d   = msd;
         end
         LET: if (hs) begin
            state_d = cnt_q == 4'd1 ? (has_num_q ? DIG : IDLE) : LET;
            let_d   = cnt_q == 4'd1 ? let_q : next_letter(let_q);
            cnt_d   = cnt_q == 4'd1 ? cnt_q : cnt_q - 4'd1;
         end
         DIG: if (hs) begin
            state_d = idx_q == '0 ? IDLE : DIG;
            idx_d   = idx_q == '0 ? idx_q : idx_q - IDX_W'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   // state and latched request registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         let_q     <= '0;
         cnt_q     <= '0;
         has_num_q <= 1'b0;
         idx_q     <= '0;
      end else begin
         state_q   <= state_d;
         let_q     <= let_d;
         cnt_q     <= cnt_d;
         has_num_q <= has_num_d;
         idx_q     <= idx_d;
      end
   end
endmodule
